// File: rtl/lut_sweep_capture.sv
// Sweeps every input vector into a combinational function block and captures
// its output F into a 2^N_IN-bit truth table, with a minterm count.
module lut_sweep_capture #(
  parameter int N_IN   = 5,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  F,
  output logic [N_IN-1:0]       stim,
  output logic                  busy,
  output logic                  done,
  output logic [(1<<N_IN)-1:0]  tt,
  output logic                  tt_valid,
  output logic [N_IN:0]         ones
);

  localparam int DEPTH = 1 << N_IN;
  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE);
  localparam logic [N_IN-1:0]  STIM_LAST = N_IN'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sample;
  logic             w_last;

  assign w_sample = (r_cnt == CNT_LAST);
  assign w_last   = (stim == STIM_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      stim     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt       <= '0;
      tt_valid <= 1'b0;
      ones     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state  <= S_SWEEP;
            busy     <= 1'b1;
            tt       <= '0;
            ones     <= '0;
            tt_valid <= 1'b0;
            stim     <= '0;
            r_cnt    <= '0;
          end
        end
        S_SWEEP: begin
          // abort wins over a coincident final sample: nothing is captured
          if (abort) begin
            r_state  <= S_IDLE;
            busy     <= 1'b0;
            stim     <= '0;
            r_cnt    <= '0;
            tt_valid <= 1'b0;
          end else if (w_sample) begin
            tt[stim] <= F;
            ones     <= ones + (N_IN + 1)'(F);
            r_cnt    <= '0;
            if (w_last) begin
              r_state  <= S_DONE;
              stim     <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              tt_valid <= 1'b1;
            end else begin
              stim <= stim + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
